vga_fb_writer: RTL and testbench

VGA_FB_WRITER -- requirements
Module: vga_fb_writer

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_fb_writer_if.sv | 24 ++
 rtl/vga_addr_calc.sv | 24 ++
 rtl/vga_fb_writer.sv | 100 ++++++++++
 tb/tb_vga_fb_writer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer writer: default geometry, op codes and FSM states.
package vga_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 19;

  localparam logic [1:0] OP_PIXEL = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_FILL = 1'b1;

endpackage

// File: rtl/vga_fb_writer_if.sv
// Command handshake plus framebuffer write port of the VGA framebuffer writer.
interface vga_fb_writer_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [9:0]        cmd_x;
  logic [9:0]        cmd_y;
  logic [23:0]       cmd_rgb;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_rgb,
    input  cmd_ready, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_rgb,
    output cmd_ready, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/vga_addr_calc.sv
// Combinational pixel address: addr = y*H_RES + x. Shared by the write and read sides.
module vga_addr_calc #(
  parameter int H_RES  = vga_pkg::H_RES,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x);
  assign y_ext = ADDR_W'(y);

  generate
    if (H_RES == 640) begin : g_shift
      // 640 = 512 + 128, so two shifts and an add replace the multiplier.
      assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_mul
      assign addr = y_ext * ADDR_W'(H_RES) + x_ext;
    end
  endgenerate
endmodule

// File: rtl/vga_fb_writer.sv
// Framebuffer writer: single-pixel writes in IDLE, full-screen fill sweeping every address in FILL.
module vga_fb_writer #(
  parameter int H_RES  = vga_pkg::H_RES,
  parameter int V_RES  = vga_pkg::V_RES,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_fb_writer_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr
);
  import vga_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t            state_reg;
  logic              fb_we_reg;
  logic [ADDR_W-1:0] fb_addr_reg;
  logic [23:0]       fb_wdata_reg;
  logic              done_reg;
  logic              err_reg;

  logic              accept;
  logic              in_range;
  logic              err_set;
  logic [ADDR_W-1:0] pix_addr;

  vga_addr_calc #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x    (bus.cmd_x),
    .y    (bus.cmd_y),
    .addr (pix_addr)
  );

  assign accept   = bus.cmd_valid && (state_reg == ST_IDLE);
  assign in_range = (32'(bus.cmd_x) < 32'(H_RES)) && (32'(bus.cmd_y) < 32'(V_RES));
  // Out-of-range pixels and reserved ops are swallowed but flagged.
  assign err_set  = accept && (((bus.cmd_op == OP_PIXEL) && !in_range) || bus.cmd_op[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      fb_we_reg    <= 1'b0;
      fb_addr_reg  <= '0;
      fb_wdata_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (err_clr) begin
        err_reg <= 1'b0;
      end else if (err_set) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          fb_we_reg <= 1'b0;
          if (accept) begin
            if ((bus.cmd_op == OP_PIXEL) && in_range) begin
              fb_we_reg    <= 1'b1;
              fb_addr_reg  <= pix_addr;
              fb_wdata_reg <= bus.cmd_rgb;
            end else if (bus.cmd_op == OP_FILL) begin
              // fb_wdata_reg doubles as the latched fill colour for the whole sweep.
              state_reg    <= ST_FILL;
              fb_we_reg    <= 1'b1;
              fb_addr_reg  <= '0;
              fb_wdata_reg <= bus.cmd_rgb;
            end
          end
        end
        ST_FILL: begin
          if (fb_addr_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            fb_we_reg <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            fb_addr_reg <= fb_addr_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_reg == ST_IDLE);
  assign bus.fb_we     = fb_we_reg;
  assign bus.fb_addr   = fb_addr_reg;
  assign bus.fb_wdata  = fb_wdata_reg;
  assign busy          = (state_reg == ST_FILL);
  assign done          = done_reg;
  assign err           = err_reg;
endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench: full-size writer for pixel/error/reset cases, a 40x30 writer for a complete fill.
module tb_vga_fb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_b, busy_b, done_b, err_b, err_clr_b;
  logic reset_s, busy_s, done_s, err_s, err_clr_s;

  int checks = 0;
  int errors = 0;

  vga_fb_writer_if #(.ADDR_W(19)) bus_b ();
  vga_fb_writer_if #(.ADDR_W(11)) bus_s ();

  vga_fb_writer #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .clk     (clk),
    .reset   (reset_b),
    .bus     (bus_b.slave),
    .busy    (busy_b),
    .done    (done_b),
    .err     (err_b),
    .err_clr (err_clr_b)
  );

  vga_fb_writer #(.H_RES(40), .V_RES(30), .ADDR_W(11)) dut_s (
    .clk     (clk),
    .reset   (reset_s),
    .bus     (bus_s.slave),
    .busy    (busy_s),
    .done    (done_s),
    .err     (err_s),
    .err_clr (err_clr_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] op, input int x, input int y,
                         input logic [23:0] rgb);
    bus_b.cmd_valid = v;
    bus_b.cmd_op    = op;
    bus_b.cmd_x     = 10'(x);
    bus_b.cmd_y     = 10'(y);
    bus_b.cmd_rgb   = rgb;
    if (v) $display("cmd op=%0d x=%0d y=%0d rgb=%06h", op, x, y, rgb);
  endtask

  task automatic test_reset();
    reset_b = 1'b1; reset_s = 1'b1; err_clr_b = 1'b0; err_clr_s = 1'b0;
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    bus_s.cmd_valid = 1'b0; bus_s.cmd_op = 2'b00; bus_s.cmd_x = '0; bus_s.cmd_y = '0;
    bus_s.cmd_rgb = '0;
    tick(); tick();
    reset_b = 1'b0; reset_s = 1'b0;
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata, busy_b, done_b, err_b} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%06h busy=%b done=%b err=%b, want all 0",
               bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata, busy_b, done_b, err_b);
    end
    checks++;
    if (bus_b.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus_b.cmd_ready);
    end
    checks++;
    if ({bus_s.fb_we, busy_s, done_s, err_s, bus_s.cmd_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_small: got %b want 00001",
                         {bus_s.fb_we, busy_s, done_s, err_s, bus_s.cmd_ready});
    end
  endtask

  task automatic test_pixel();
    drive_b(1'b1, 2'b00, 3, 2, 24'hFF0000);
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata} !== {1'b1, 19'd1283, 24'hFF0000}) begin
      errors++;
      $display("FAIL pixel_write: got we=%b addr=%0d wdata=%06h want we=1 addr=1283 wdata=ff0000",
               bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata);
    end
    // No handshake: the changed command fields must be ignored and outputs held.
    drive_b(1'b0, 2'b00, 7, 9, 24'h123456);
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata, err_b} !== {1'b0, 19'd1283, 24'hFF0000, 1'b0}) begin
      errors++;
      $display("FAIL pixel_hold: got we=%b addr=%0d wdata=%06h err=%b want we=0 addr=1283 wdata=ff0000 err=0",
               bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata, err_b);
    end
  endtask

  task automatic test_back_to_back();
    drive_b(1'b1, 2'b00, 639, 479, 24'h123456);
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata} !== {1'b1, 19'd307199, 24'h123456}) begin
      errors++;
      $display("FAIL b2b_first: got we=%b addr=%0d wdata=%06h want we=1 addr=307199 wdata=123456",
               bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata);
    end
    drive_b(1'b1, 2'b00, 0, 0, 24'hABCDEF);
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata} !== {1'b1, 19'd0, 24'hABCDEF}) begin
      errors++;
      $display("FAIL b2b_second: got we=%b addr=%0d wdata=%06h want we=1 addr=0 wdata=abcdef",
               bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata);
    end
    drive_b(1'b1, 2'b00, 100, 1, 24'h010203);
    tick();
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr} !== {1'b1, 19'd740}) begin
      errors++; $display("FAIL b2b_third: got we=%b addr=%0d want we=1 addr=740",
                         bus_b.fb_we, bus_b.fb_addr);
    end
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    tick();
  endtask

  task automatic test_range_err();
    drive_b(1'b1, 2'b00, 640, 0, 24'h111111);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    checks++;
    if ({bus_b.fb_we, err_b, bus_b.fb_addr} !== {1'b0, 1'b1, 19'd740}) begin
      errors++; $display("FAIL x_range: got we=%b err=%b addr=%0d want we=0 err=1 addr=740",
                         bus_b.fb_we, err_b, bus_b.fb_addr);
    end
    tick();
    checks++;
    if (err_b !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err_b);
    end
    err_clr_b = 1'b1;
    tick();
    err_clr_b = 1'b0;
    checks++;
    if (err_b !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_b);
    end
    drive_b(1'b1, 2'b00, 0, 480, 24'h222222);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    checks++;
    if ({bus_b.fb_we, err_b} !== 2'b01) begin
      errors++; $display("FAIL y_range: got we=%b err=%b want we=0 err=1", bus_b.fb_we, err_b);
    end
    err_clr_b = 1'b1;
    tick();
    // Clear and a new error in the same cycle: clear must win.
    drive_b(1'b1, 2'b00, 700, 3, 24'h333333);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    err_clr_b = 1'b0;
    checks++;
    if ({bus_b.fb_we, err_b} !== 2'b00) begin
      errors++; $display("FAIL clr_priority: got we=%b err=%b want we=0 err=0", bus_b.fb_we, err_b);
    end
  endtask

  task automatic test_reserved_op();
    drive_b(1'b1, 2'b11, 5, 5, 24'h444444);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    checks++;
    if ({bus_b.fb_we, err_b, bus_b.cmd_ready, busy_b} !== 4'b0110) begin
      errors++; $display("FAIL op11: got we=%b err=%b ready=%b busy=%b want 0 1 1 0",
                         bus_b.fb_we, err_b, bus_b.cmd_ready, busy_b);
    end
    err_clr_b = 1'b1;
    tick();
    err_clr_b = 1'b0;
    drive_b(1'b1, 2'b10, 5, 5, 24'h555555);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    checks++;
    if ({bus_b.fb_we, err_b, bus_b.cmd_ready} !== 3'b011) begin
      errors++; $display("FAIL op10: got we=%b err=%b ready=%b want 0 1 1",
                         bus_b.fb_we, err_b, bus_b.cmd_ready);
    end
    err_clr_b = 1'b1;
    tick();
    err_clr_b = 1'b0;
  endtask

  task automatic test_fill_small();
    logic [38:0] got, exp;
    int done_count = 0;
    bus_s.cmd_valid = 1'b1; bus_s.cmd_op = 2'b01; bus_s.cmd_rgb = 24'h00FF00;
    $display("cmd small op=1 rgb=00ff00");
    tick();
    for (int k = 1; k <= 1200; k++) begin
      // {we, addr, wdata, busy, ready, done}
      got = {bus_s.fb_we, bus_s.fb_addr, bus_s.fb_wdata, busy_s, bus_s.cmd_ready, done_s};
      exp = {1'b1, 11'(k - 1), 24'h00FF00, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fill_write_%0d: got %h want %h", k, got, exp);
      end
      // A pixel command offered mid-fill must not be taken.
      if (k >= 2 && k <= 9) begin
        bus_s.cmd_valid = 1'b1; bus_s.cmd_op = 2'b00; bus_s.cmd_x = 10'd5; bus_s.cmd_y = 10'd5;
        bus_s.cmd_rgb = 24'hFFFFFF;
      end else begin
        bus_s.cmd_valid = 1'b0;
      end
      if (done_s === 1'b1) done_count++;
      tick();
    end
    checks++;
    if ({bus_s.fb_we, busy_s, bus_s.cmd_ready, done_s} !== 4'b0011) begin
      errors++; $display("FAIL fill_done: got we=%b busy=%b ready=%b done=%b want 0 0 1 1",
                         bus_s.fb_we, busy_s, bus_s.cmd_ready, done_s);
    end
    tick();
    checks++;
    if ({done_s, done_count, bus_s.fb_addr, err_s} !== {1'b0, 32'd0, 11'd1199, 1'b0}) begin
      errors++; $display("FAIL fill_after: got done=%b early_done=%0d addr=%0d err=%b want 0 0 1199 0",
                         done_s, done_count, bus_s.fb_addr, err_s);
    end
  endtask

  task automatic test_fill_reset();
    logic [21:0] got, exp;
    drive_b(1'b1, 2'b01, 0, 0, 24'h0000FF);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    for (int k = 1; k <= 1000; k++) begin
      got = {bus_b.fb_we, bus_b.fb_addr, busy_b, done_b};
      exp = {1'b1, 19'(k - 1), 1'b1, 1'b0};
      if (k == 1 || k == 500 || k == 1000) begin
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL bigfill_write_%0d: got %h want %h", k, got, exp);
        end
      end
      if (k == 1000) reset_b = 1'b1;
      tick();
    end
    reset_b = 1'b0;
    checks++;
    if ({bus_b.fb_we, busy_b, done_b, bus_b.fb_addr} !== {3'b000, 19'd0}) begin
      errors++; $display("FAIL abort_fill: got we=%b busy=%b done=%b addr=%0d want 0 0 0 0",
                         bus_b.fb_we, busy_b, done_b, bus_b.fb_addr);
    end
    tick();
    checks++;
    if ({done_b, bus_b.cmd_ready, busy_b} !== 3'b010) begin
      errors++; $display("FAIL abort_idle: got done=%b ready=%b busy=%b want 0 1 0",
                         done_b, bus_b.cmd_ready, busy_b);
    end
    drive_b(1'b1, 2'b00, 1, 1, 24'h0A0B0C);
    tick();
    drive_b(1'b0, 2'b00, 0, 0, 24'h0);
    checks++;
    if ({bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata} !== {1'b1, 19'd641, 24'h0A0B0C}) begin
      errors++; $display("FAIL post_abort_pixel: got we=%b addr=%0d wdata=%06h want 1 641 0a0b0c",
                         bus_b.fb_we, bus_b.fb_addr, bus_b.fb_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_back_to_back();
    test_range_err();
    test_reserved_op();
    test_fill_small();
    test_fill_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
